bitmap_renderer: RTL and testbench

- Reads the 16x32 `display` bitmap produced by game_state and draws it on the 160x120 vga_adapter through its plot interface.
- Each cell becomes a CELL_W x CELL_H block of pixels.
- Sits between game_state and vga_adapter: drives vga_adapter `x`, `y`, `colour` and `plot`; `start` comes from the top-level frame timer.
- Snapshots the bitmap when a frame starts, so game_state can keep shifting while a frame is being drawn.

---
 rtl/bitmap_renderer_if.sv | 22 ++
 rtl/bitmap_renderer.sv | 176 +++++++++++++++++
 tb/tb_bitmap_renderer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitmap_renderer_if.sv
// Pixel-plot bus between the frame renderer and its client: start/bitmap in,
// vga_adapter plot signals and frame status out.
interface bitmap_renderer_if;
    logic         start;
    logic [511:0] display;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot;
    logic         busy;
    logic         done;

    modport master (
        output start, display,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, display,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/bitmap_renderer.sv
// Draws the 16x32 cell bitmap as CELL_W x CELL_H pixel blocks on the vga plot bus.
// Optional BITMAP_RENDERER_DIRTY_EN redraws only cells that changed since the last frame.
module bitmap_renderer #(
    parameter int unsigned CELL_W     = 10,
    parameter int unsigned CELL_H     = 3,
    parameter int unsigned X_OFF      = 0,
    parameter int unsigned Y_OFF      = 12,
    parameter logic [2:0]  ON_COLOUR  = 3'b111,
    parameter logic [2:0]  OFF_COLOUR = 3'b000
) (
    input logic              clock,
    input logic              resetn,
    bitmap_renderer_if.slave bus
);
    localparam int unsigned PXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned PYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t         state_q, state_d;
    logic [4:0]     r_q, r_d;
    logic [3:0]     c_q, c_d;
    logic [PYW-1:0] py_q, py_d;
    logic [PXW-1:0] px_q, px_d;
    logic [511:0]   shadow_q, shadow_d;
    logic [7:0]     x_q, x_d;
    logic [6:0]     y_q, y_d;
    logic [2:0]     colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef BITMAP_RENDERER_DIRTY_EN
    logic [511:0]   prev_q, prev_d;
    logic           full_q, full_d;
`endif

    logic [8:0] cell_idx;
    logic       cell_bit;
    logic       px_last, py_last, cell_last;
    logic       draw_cell;
    logic       next_cell;

    // {c, r} is exactly 32*c + r
    assign cell_idx  = {c_q, r_q};
    assign cell_bit  = shadow_q[cell_idx];
    assign px_last   = (px_q == PXW'(CELL_W - 1));
    assign py_last   = (py_q == PYW'(CELL_H - 1));
    assign cell_last = (r_q == 5'd31) && (c_q == 4'd15);

`ifdef BITMAP_RENDERER_DIRTY_EN
    assign draw_cell = full_q || (cell_bit != prev_q[cell_idx]);
`else
    assign draw_cell = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        py_d      = py_q;
        px_d      = px_q;
        shadow_d  = shadow_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = plot_q;
        busy_d    = busy_q;
        done_d    = done_q;
        next_cell = 1'b0;
`ifdef BITMAP_RENDERER_DIRTY_EN
        prev_d    = prev_q;
        full_d    = full_q;
`endif
        case (state_q)
            IDLE: begin
                plot_d = 1'b0;
                done_d = 1'b0;
                if (bus.start) begin
                    shadow_d = bus.display;
                    r_d      = '0;
                    c_d      = '0;
                    py_d     = '0;
                    px_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (draw_cell) begin
                    plot_d   = 1'b1;
                    x_d      = 8'(X_OFF + 32'(c_q) * CELL_W + 32'(px_q));
                    y_d      = 7'(Y_OFF + 32'(r_q) * CELL_H + 32'(py_q));
                    colour_d = cell_bit ? ON_COLOUR : OFF_COLOUR;
                    if (!px_last) begin
                        px_d = px_q + 1'b1;
                    end else begin
                        px_d = '0;
                        if (!py_last) begin
                            py_d = py_q + 1'b1;
                        end else begin
                            py_d      = '0;
                            next_cell = 1'b1;
                        end
                    end
                end else begin
                    // Unchanged cell: one idle cycle, then straight to the next cell
                    plot_d    = 1'b0;
                    px_d      = '0;
                    py_d      = '0;
                    next_cell = 1'b1;
                end
                if (next_cell) begin
                    c_d = c_q + 1'b1;
                    if (c_q == 4'd15) r_d = r_q + 1'b1;
                    if (cell_last) state_d = FIN;
                end
            end
            FIN: begin
                plot_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BITMAP_RENDERER_DIRTY_EN
                prev_d  = shadow_q;
                full_d  = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            r_q      <= '0;
            c_q      <= '0;
            py_q     <= '0;
            px_q     <= '0;
            shadow_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BITMAP_RENDERER_DIRTY_EN
            prev_q   <= '0;
            full_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            py_q     <= py_d;
            px_q     <= px_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BITMAP_RENDERER_DIRTY_EN
            prev_q   <= prev_d;
            full_q   <= full_d;
`endif
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_bitmap_renderer.sv
// Bench for bitmap_renderer: a frame-level pixel-list model checked every cycle,
// plus literal expectations for frame geometry, timing and reset behaviour.
module tb_bitmap_renderer;
    localparam int CW = 10;
    localparam int CH = 3;
    localparam int XO = 0;
    localparam int YO = 12;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bitmap_renderer_if bus();

    bitmap_renderer #(
        .CELL_W(CW), .CELL_H(CH), .X_OFF(XO), .Y_OFF(YO),
        .ON_COLOUR(3'b111), .OFF_COLOUR(3'b000)
    ) dut (
        .clock (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       busy;
        logic       done;
    } obs_t;

    // Model: a frame is a list of per-cycle outputs derived from the snapshot
    obs_t         q[$];
    obs_t         exp_o;
    bit           m_valid = 0;
    logic [511:0] m_snap, m_prev;
    bit           m_full;

    int n_checks = 0;
    int n_fail   = 0;

    int frame_plots, frame_on, first_x, first_y, last_x, last_y;
    int on_xmin, on_xmax, on_ymin, on_ymax, done_count;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void build_frame();
        obs_t e;
        bit   draw;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 16; c++) begin
                draw = 1;
`ifdef BITMAP_RENDERER_DIRTY_EN
                draw = m_full || (m_snap[32*c+r] != m_prev[32*c+r]);
`endif
                if (draw) begin
                    for (int py = 0; py < CH; py++) begin
                        for (int px = 0; px < CW; px++) begin
                            e.plot   = 1'b1;
                            e.x      = 8'(XO + c*CW + px);
                            e.y      = 7'(YO + r*CH + py);
                            e.colour = m_snap[32*c+r] ? 3'b111 : 3'b000;
                            e.busy   = 1'b1;
                            e.done   = 1'b0;
                            q.push_back(e);
                        end
                    end
                end else begin
                    e = '0;
                    e.busy = 1'b1;
                    q.push_back(e);
                end
            end
        end
        e = '0;
        e.done = 1'b1;
        q.push_back(e);
    endfunction

    always @(posedge clk) begin
        obs_t e;
        if (!resetn) begin
            q.delete();
            exp_o   = '0;
            m_full  = 1;
            m_prev  = '0;
            m_valid = 1;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (!e.plot) begin
                e.x      = exp_o.x;
                e.y      = exp_o.y;
                e.colour = exp_o.colour;
            end
            exp_o = e;
            if (e.done) begin
                m_prev = m_snap;
                m_full = 0;
            end
        end else begin
            exp_o.plot = 1'b0;
            exp_o.done = 1'b0;
            if (bus.start) begin
                m_snap = bus.display;
                build_frame();
                exp_o.busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        obs_t act;
        act.plot   = bus.plot;
        act.x      = bus.x;
        act.y      = bus.y;
        act.colour = bus.colour;
        act.busy   = bus.busy;
        act.done   = bus.done;
        if (m_valid) begin
            n_checks++;
            if (act !== exp_o) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, exp_o);
            end
        end
        if (bus.plot === 1'b1) begin
            if (frame_plots == 0) begin
                first_x = int'(bus.x);
                first_y = int'(bus.y);
            end
            frame_plots++;
            last_x = int'(bus.x);
            last_y = int'(bus.y);
            if (bus.colour === 3'b111) begin
                frame_on++;
                if (int'(bus.x) < on_xmin) on_xmin = int'(bus.x);
                if (int'(bus.x) > on_xmax) on_xmax = int'(bus.x);
                if (int'(bus.y) < on_ymin) on_ymin = int'(bus.y);
                if (int'(bus.y) > on_ymax) on_ymax = int'(bus.y);
            end
        end
        if (bus.done === 1'b1) done_count++;
    end

    task automatic clear_stats();
        frame_plots = 0; frame_on = 0; done_count = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        on_xmin = 999; on_xmax = -1; on_ymin = 999; on_ymax = -1;
    endtask

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_frame(input int toggle_at, output int done_at, output int busy_at_done);
        #1;
        clear_stats();
        bus.start    = 1'b1;
        done_at      = -1;
        busy_at_done = -1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == toggle_at) begin
                bus.display = ~bus.display;
                bus.start   = 1'b1;
            end
            if (bus.done === 1'b1) begin
                done_at      = cyc;
                busy_at_done = int'(bus.busy);
                break;
            end
        end
    endtask

    function automatic logic [511:0] rand_bitmap();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_plot"},   int'(bus.plot),   0);
        check({tag, "_busy"},   int'(bus.busy),   0);
        check({tag, "_done"},   int'(bus.done),   0);
        check({tag, "_x"},      int'(bus.x),      0);
        check({tag, "_y"},      int'(bus.y),      0);
        check({tag, "_colour"}, int'(bus.colour), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           done_at, busy_at_done, ones;
        logic [511:0] snap;

        resetn      = 1'b0;
        bus.start   = 1'b1;
        bus.display = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        resetn    = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

`ifdef BITMAP_RENDERER_DIRTY_EN
        run_frame(-1, done_at, busy_at_done);
        #1;
        check("dirty_f1_done_at", done_at, 15361);
        check("dirty_f1_plots", frame_plots, 15360);
        repeat (3) @(negedge clk);
        run_frame(-1, done_at, busy_at_done);
        #1;
        check("dirty_f2_done_at", done_at, 513);
        check("dirty_f2_plots", frame_plots, 0);
        @(negedge clk);
        bus.display[32*3+5] = 1'b1;
        run_frame(-1, done_at, busy_at_done);
        #1;
        check("dirty_f3_done_at", done_at, 542);
        check("dirty_f3_plots", frame_plots, 30);
        check("dirty_f3_on", frame_on, 30);
        check("dirty_f3_xmin", on_xmin, 30);
        check("dirty_f3_ymax", on_ymax, 29);
        repeat (5) @(negedge clk);
`else
        // All-zero frame
        run_frame(-1, done_at, busy_at_done);
        #1;
        check("zero_done_at", done_at, 15361);
        check("zero_busy_at_done", busy_at_done, 0);
        check("zero_plots", frame_plots, 15360);
        check("zero_on", frame_on, 0);
        check("zero_first_x", first_x, 0);
        check("zero_first_y", first_y, 12);
        check("zero_last_x", last_x, 159);
        check("zero_last_y", last_y, 107);

        // Single cell, started in the cycle done is high
        bus.display = '0;
        bus.display[32*3+5] = 1'b1;
        run_frame(-1, done_at, busy_at_done);
        #1;
        check("cell_done_at", done_at, 15361);
        check("cell_plots", frame_plots, 15360);
        check("cell_on", frame_on, 30);
        check("cell_xmin", on_xmin, 30);
        check("cell_xmax", on_xmax, 39);
        check("cell_ymin", on_ymin, 27);
        check("cell_ymax", on_ymax, 29);

        // Toggle bitmap and retry start mid-frame
        repeat (2) @(negedge clk);
        bus.display = rand_bitmap();
        snap = bus.display;
        ones = $countones(snap);
        run_frame(100, done_at, busy_at_done);
        #1;
        check("toggle_done_at", done_at, 15361);
        check("toggle_on", frame_on, ones * 30);
        repeat (20) @(negedge clk);
        #1;
        check("toggle_done_count", done_count, 1);
        check("toggle_busy_after", int'(bus.busy), 0);

        // Reset at plot 5000
        @(negedge clk);
        bus.display = rand_bitmap();
        #1;
        clear_stats();
        bus.start = 1'b1;
        for (int k = 0; k <= 5000; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        check("midreset_plots", frame_plots, 5000);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("midreset_no_done", done_count, 0);

        // Complete frame after the aborted one
        @(negedge clk);
        bus.display = rand_bitmap();
        ones = $countones(bus.display);
        run_frame(-1, done_at, busy_at_done);
        #1;
        check("after_reset_done_at", done_at, 15361);
        check("after_reset_plots", frame_plots, 15360);
        check("after_reset_on", frame_on, ones * 30);
        repeat (5) @(negedge clk);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
